// File: rtl/op_issuer_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the operation issuer.
package op_issuer_pkg;

  localparam logic [3:0] OP_IDLE   = 4'd0;
  localparam logic [3:0] OP_MATMUL = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_READ   = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_MATMUL,
    S_WRITE,
    S_READ,
    S_NOP,
    S_GAP
  } state_t;

  // Opcodes above OP_READ are not understood by the controller.
  function automatic logic op_legal(input logic [3:0] opc);
    return opc <= OP_READ;
  endfunction

endpackage

// File: rtl/op_issuer_fifo.sv
// Command FIFO: DEPTH x WIDTH, synchronous push/pop, wrap-bit pointers for full/empty.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of storage and pointers; the extra pointer bit tells full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointer registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/op_issuer.sv
// Host-side initiator: queues operation words and drives each onto the controller
// for its required duration, streaming write/read words over valid/ready.
module op_issuer
  import op_issuer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WORDS     = 64,
  parameter int MM_CYCLES = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic [31:0] ctl_operation,
  output logic [31:0] ctl_in_data,
  input  logic [31:0] ctl_out_data,
  output logic        ctl_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_MAX = (MM_CYCLES > WORDS) ? MM_CYCLES : WORDS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MM_LAST    = CW'(MM_CYCLES - 1);
  localparam logic [CW-1:0] WORDS_LAST = CW'(WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic        ctl_en;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  op_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .push_data(cmd_op),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sequencing: every step is gated by enable so a low enable freezes state and counter.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (enable) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          cnt_d    = '0;
          case (fifo_head[3:0])
            OP_IDLE:   state_d = S_NOP;
            OP_MATMUL: state_d = S_MATMUL;
            OP_WRITE:  state_d = S_WRITE;
            OP_READ:   state_d = S_READ;
            default:   state_d = S_GAP;
          endcase
        end
      end
      S_MATMUL: begin
        if (enable) begin
          if (cnt_q == MM_LAST) state_d = S_GAP;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        if (enable && wr_valid) begin
          if (cnt_q == WORDS_LAST) state_d = S_GAP;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        if (enable && rd_ready) begin
          if (cnt_q == WORDS_LAST) state_d = S_GAP;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      S_NOP: begin
        if (enable) state_d = S_GAP;
      end
      S_GAP: begin
        if (enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller-side muxing; the opcode is only ever driven from the three active states.
  always_comb begin
    ctl_operation = '0;
    ctl_in_data   = '0;
    ctl_en        = enable;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_data       = '0;
    done          = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_MATMUL: ctl_operation = op_q;
      S_WRITE: begin
        ctl_operation = op_q;
        ctl_in_data   = wr_data;
        ctl_en        = enable && wr_valid;
        wr_ready      = enable && wr_valid;
      end
      S_READ: begin
        ctl_operation = op_q;
        rd_data       = ctl_out_data;
        rd_valid      = enable;
        ctl_en        = enable && rd_ready;
      end
      S_ISSUE: err  = enable && !op_legal(fifo_head[3:0]);
      S_GAP:   done = enable && op_legal(op_q[3:0]);
      default: ;
    endcase
  end

  // The controller is held off for as long as reset is asserted.
  assign ctl_enable = ctl_en && !reset;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // State, operation register and duration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// Directed bench for op_issuer: table of single operations plus hand-written
// sequences for FIFO back-pressure, illegal opcodes and mid-operation reset.
module tb_op_issuer;

  logic        clk = 1'b0;
  logic        reset, enable, cmdValid, wrValid, rdReady;
  logic [31:0] cmdOp, wrData, ctlOutData;
  logic        cmdReady, wrReady, rdValid, ctlEnable, busy, done, err;
  logic [31:0] rdData, ctlOperation, ctlInData;

  op_issuer #(.DEPTH(4), .WORDS(64), .MM_CYCLES(96)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cmd_valid    (cmdValid),
    .cmd_ready    (cmdReady),
    .cmd_op       (cmdOp),
    .wr_valid     (wrValid),
    .wr_ready     (wrReady),
    .wr_data      (wrData),
    .rd_valid     (rdValid),
    .rd_ready     (rdReady),
    .rd_data      (rdData),
    .ctl_operation(ctlOperation),
    .ctl_in_data  (ctlInData),
    .ctl_out_data (ctlOutData),
    .ctl_enable   (ctlEnable),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, cleared before each scenario
  logic [31:0] watchOp, prevOp;
  logic        freeze;
  int cyc, actCnt, doneCnt, errCnt, badSeen, wrK, rdK, rdStall, lastAct, doneAt;
  int enBad, wrBad, rdBad, pushAcc;
  logic [31:0] pushQ[$];
  logic [31:0] issued[$];
  int issueCyc[$];
  int acceptCyc[$];

  typedef struct {
    logic [31:0] op;
    int          rdStall;
    logic        freeze;
    int          expAct;
    int          expWr;
    int          expRd;
    int          expDone;
    int          expErr;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clearMonitor(input logic [31:0] op, input int stall, input logic frz);
    watchOp = op; rdStall = stall; freeze = frz;
    actCnt = 0; doneCnt = 0; errCnt = 0; badSeen = 0; wrK = 0; rdK = 0;
    lastAct = 0; doneAt = -1; enBad = 0; wrBad = 0; rdBad = 0; pushAcc = 0;
    pushQ.delete(); issued.delete(); issueCyc.delete(); acceptCyc.delete();
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later.
  task automatic applyStimulus();
    logic act;
    @(negedge clk);
    cyc++;
    cmdValid   = (pushQ.size() != 0);
    cmdOp      = cmdValid ? pushQ[0] : 32'h0;
    act        = (watchOp != 0) && (ctlOperation == watchOp);
    wrValid    = act && (watchOp[3:0] == 4'd2) && (actCnt % 2 == 1);
    wrData     = 32'h1000_0000 + 32'(wrK);
    rdReady    = act && (watchOp[3:0] == 4'd3) && (actCnt >= rdStall);
    enable     = !(freeze && act && actCnt >= 20 && actCnt < 25);
    ctlOutData = 32'hA500_0000 + 32'(cyc);
    #1;
    if (cmdValid && cmdReady) begin
      void'(pushQ.pop_front());
      pushAcc++;
      acceptCyc.push_back(cyc);
    end
    if (ctlOperation != 0 && prevOp == 0) begin
      issued.push_back(ctlOperation);
      issueCyc.push_back(cyc);
    end
    prevOp = ctlOperation;
    if (act) begin actCnt++; lastAct = cyc; end
    if (ctlOperation[3:0] > 4'd3) badSeen++;
    if (done) begin doneCnt++; doneAt = cyc; end
    if (err) errCnt++;
    if (!enable && ctlEnable) enBad++;
    if (act && watchOp[3:0] == 4'd2) begin
      if (wrValid && wrReady) begin
        if (ctlInData !== wrData || !ctlEnable) wrBad++;
        wrK++;
      end
      if (!wrValid && (wrReady || ctlEnable)) wrBad++;
    end else if (ctlInData != 0 || wrReady) begin
      wrBad++;
    end
    if (act && watchOp[3:0] == 4'd3) begin
      if (!rdValid) rdBad++;
      if (rdReady) begin
        if (rdData !== ctlOutData || !ctlEnable) rdBad++;
        rdK++;
      end else if (ctlEnable) begin
        rdBad++;
      end
    end else if (rdValid) begin
      rdBad++;
    end
  endtask

  task automatic runUntilIdle(input string name, input int bound);
    int n = 0;
    applyStimulus();
    applyStimulus();
    while ((busy || pushQ.size() != 0) && n < bound) begin
      applyStimulus();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("[TB] FAIL %s timeout actual=%0d cycles required<%0d", name, n, bound);
    end
  endtask

  task automatic waitActive(input string name, input int target);
    int n = 0;
    while (actCnt < target && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, " reached"}, 32'(actCnt >= target), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ctl_operation"}, ctlOperation, 32'h0);
    checkOutput({tag, " ctl_in_data"}, ctlInData, 32'h0);
    checkOutput({tag, " rd_data"}, rdData, 32'h0);
    checkOutput({tag, " ctl_enable"}, 32'(ctlEnable), 32'd0);
    checkOutput({tag, " flags"}, {27'b0, wrReady, rdValid, busy, done, err}, 32'h0);
    checkOutput({tag, " cmd_ready"}, 32'(cmdReady), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=expired required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0001,  0, 1'b0,  96,  0,  0, 1, 0};
    vecs[1] = '{32'h0000_0012,  0, 1'b0, 128, 64,  0, 1, 0};
    vecs[2] = '{32'h0000_0013, 10, 1'b0,  74,  0, 64, 1, 0};
    vecs[3] = '{32'h0000_0023,  0, 1'b0,  64,  0, 64, 1, 0};
    vecs[4] = '{32'h0000_0050,  0, 1'b0,   0,  0,  0, 1, 0};
    vecs[5] = '{32'h0000_0009,  0, 1'b0,   0,  0,  0, 0, 1};
    vecs[6] = '{32'hABC0_0001,  0, 1'b1, 101,  0,  0, 1, 0};

    reset = 1'b1; enable = 1'b1; cmdValid = 1'b0; cmdOp = '0;
    wrValid = 1'b0; wrData = '0; rdReady = 1'b0; ctlOutData = 32'h5A5A_5A5A;
    cyc = 0; prevOp = '0;
    clearMonitor(32'h0, 0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single operations from the table
    for (int i = 0; i < 7; i++) begin
      clearMonitor(vecs[i].op, vecs[i].rdStall, vecs[i].freeze);
      pushQ.push_back(vecs[i].op);
      runUntilIdle($sformatf("v%0d", i), 1000);
      checkOutput($sformatf("v%0d active", i), 32'(actCnt), 32'(vecs[i].expAct));
      checkOutput($sformatf("v%0d wr", i), 32'(wrK), 32'(vecs[i].expWr));
      checkOutput($sformatf("v%0d rd", i), 32'(rdK), 32'(vecs[i].expRd));
      checkOutput($sformatf("v%0d done", i), 32'(doneCnt), 32'(vecs[i].expDone));
      checkOutput($sformatf("v%0d err", i), 32'(errCnt), 32'(vecs[i].expErr));
      checkOutput($sformatf("v%0d illegal_op", i), 32'(badSeen), 32'd0);
      checkOutput($sformatf("v%0d enable", i), 32'(enBad), 32'd0);
      checkOutput($sformatf("v%0d wr_path", i), 32'(wrBad), 32'd0);
      checkOutput($sformatf("v%0d rd_path", i), 32'(rdBad), 32'd0);
      if (vecs[i].expAct > 0)
        checkOutput($sformatf("v%0d gap", i), 32'(doneAt), 32'(lastAct + 1));
    end

    // Illegal opcode immediately followed by a matmul
    clearMonitor(32'h1, 0, 1'b0);
    pushQ = '{32'h7, 32'h1};
    runUntilIdle("illegal", 1000);
    checkOutput("illegal err", 32'(errCnt), 32'd1);
    checkOutput("illegal op_seen", 32'(badSeen), 32'd0);
    checkOutput("illegal mm_active", 32'(actCnt), 32'd96);
    checkOutput("illegal done", 32'(doneCnt), 32'd1);

    // FIFO fill behind a running matmul, then issue order
    clearMonitor(32'h1, 0, 1'b0);
    pushQ.push_back(32'h1);
    waitActive("fill start", 3);
    pushAcc = 0;
    acceptCyc.delete();
    pushQ = '{32'h101, 32'h201, 32'h301, 32'h401, 32'h501};
    repeat (8) applyStimulus();
    checkOutput("fill accepted", 32'(pushAcc), 32'd4);
    checkOutput("fill cmd_ready", 32'(cmdReady), 32'd0);
    checkOutput("fill pending", 32'(pushQ.size()), 32'd1);
    runUntilIdle("fill", 3000);
    checkOutput("order count", 32'(issued.size()), 32'd6);
    if (issued.size() == 6) begin
      checkOutput("order 0", issued[0], 32'h1);
      checkOutput("order 1", issued[1], 32'h101);
      checkOutput("order 2", issued[2], 32'h201);
      checkOutput("order 3", issued[3], 32'h301);
      checkOutput("order 4", issued[4], 32'h401);
      checkOutput("order 5", issued[5], 32'h501);
      checkOutput("fifth accept", 32'(acceptCyc[4]), 32'(issueCyc[1]));
    end

    // Reset at cycle 40 of a matmul with a write still queued
    clearMonitor(32'h1, 0, 1'b0);
    pushQ = '{32'h1, 32'h12};
    waitActive("mid reset", 40);
    @(negedge clk);
    reset = 1'b1;
    ctlOutData = 32'hDEAD_BEEF;
    #1;
    checkResetOutputs("midreset");
    repeat (3) applyStimulus();
    checkOutput("midreset done", 32'(doneCnt), 32'd0);
    checkOutput("midreset err", 32'(errCnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus();
    checkOutput("midreset fifo_empty", 32'(busy), 32'd0);
    clearMonitor(32'h1, 0, 1'b0);
    pushQ.push_back(32'h1);
    runUntilIdle("after reset", 1000);
    checkOutput("after reset active", 32'(actCnt), 32'd96);
    checkOutput("after reset done", 32'(doneCnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
